// File: rtl/axi4_wr_store_fwd.sv
// Store-and-forward AXI4 write buffer: an AW is only forwarded once its whole W burst is stored.
// Define AXI4_WR_STORE_FWD_LENCHK_EN to flag bursts longer than the W-FIFO on err_len_ovf.
module axi4_wr_store_fwd #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int WDEPTH = 256,
  parameter int ADEPTH = 4
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic                err_len_ovf
);
  localparam int AA      = $clog2(ADEPTH);
  localparam int WA      = $clog2(WDEPTH);
  localparam int CNT_W   = WA + 1;
  localparam int AW_BITS = ID_W + ADDR_W + 8;
  localparam int W_BITS  = DATA_W + DATA_W/8 + 1;
  localparam logic [AA:0]      AW_ONE  = {{AA{1'b0}}, 1'b1};
  localparam logic [WA:0]      W_ONE   = {{WA{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               ready_en;
  logic [AW_BITS-1:0] aw_mem [ADEPTH];
  logic [W_BITS-1:0]  w_mem [WDEPTH];
  logic [AA:0]        aw_wptr, aw_rptr;
  logic [WA:0]        w_wptr, w_rptr;
  logic [CNT_W-1:0]   bursts_rdy, bursts_rel;
  logic               aw_full, aw_empty, w_full, w_empty;
  logic               aw_push, aw_pop, w_push, w_pop, wlast_in, wlast_out;
  logic [AW_BITS-1:0] aw_head;
  logic [W_BITS-1:0]  w_head;

  // Keeps both readys low until the first clock edge after reset release.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  assign aw_full  = (aw_wptr[AA] != aw_rptr[AA]) && (aw_wptr[AA-1:0] == aw_rptr[AA-1:0]);
  assign aw_empty = (aw_wptr == aw_rptr);
  assign w_full   = (w_wptr[WA] != w_rptr[WA]) && (w_wptr[WA-1:0] == w_rptr[WA-1:0]);
  assign w_empty  = (w_wptr == w_rptr);

  assign s_awready = ready_en & ~aw_full;
  assign s_wready  = ready_en & ~w_full;
  assign m_awvalid = ~aw_empty & (bursts_rdy != '0);
  assign m_wvalid  = ~w_empty & (bursts_rel != '0);

  assign aw_push   = s_awvalid & s_awready;
  assign aw_pop    = m_awvalid & m_awready;
  assign w_push    = s_wvalid & s_wready;
  assign w_pop     = m_wvalid & m_wready;
  assign wlast_in  = w_push & s_wlast;
  assign wlast_out = w_pop & m_wlast;

  // Payloads are forced to zero when not valid so reset drives them low; stable while valid.
  assign aw_head = aw_mem[aw_rptr[AA-1:0]];
  assign w_head  = w_mem[w_rptr[WA-1:0]];
  assign {m_awid, m_awaddr, m_awlen} = m_awvalid ? aw_head : '0;
  assign {m_wdata, m_wstrb, m_wlast} = m_wvalid ? w_head : '0;

  always_ff @(posedge axi_aclk) begin
    if (aw_push) aw_mem[aw_wptr[AA-1:0]] <= {s_awid, s_awaddr, s_awlen};
    if (w_push)  w_mem[w_wptr[WA-1:0]]   <= {s_wdata, s_wstrb, s_wlast};
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_wptr <= '0;
      aw_rptr <= '0;
      w_wptr  <= '0;
      w_rptr  <= '0;
    end else begin
      if (aw_push) aw_wptr <= aw_wptr + AW_ONE;
      if (aw_pop)  aw_rptr <= aw_rptr + AW_ONE;
      if (w_push)  w_wptr  <= w_wptr + W_ONE;
      if (w_pop)   w_rptr  <= w_rptr + W_ONE;
    end
  end

  // bursts_rdy: fully stored bursts whose AW has not left; bursts_rel: released bursts still streaming.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      bursts_rdy <= '0;
      bursts_rel <= '0;
    end else begin
      case ({wlast_in, aw_pop})
        2'b10:   bursts_rdy <= bursts_rdy + CNT_ONE;
        2'b01:   bursts_rdy <= bursts_rdy - CNT_ONE;
        default: bursts_rdy <= bursts_rdy;
      endcase
      case ({aw_pop, wlast_out})
        2'b10:   bursts_rel <= bursts_rel + CNT_ONE;
        2'b01:   bursts_rel <= bursts_rel - CNT_ONE;
        default: bursts_rel <= bursts_rel;
      endcase
    end
  end

`ifdef AXI4_WR_STORE_FWD_LENCHK_EN
  // A burst longer than the W-FIFO can never be fully stored, so its AW would stall forever.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) err_len_ovf <= 1'b0;
    else if (aw_push && (int'({1'b0, s_awlen}) + 1 > WDEPTH)) err_len_ovf <= 1'b1;
  end
`else
  assign err_len_ovf = 1'b0;
`endif

endmodule

// File: doc/axi4_wr_store_fwd.md
AXI4_WR_STORE_FWD -- requirements
Module: axi4_wr_store_fwd

Interface
REQ-001 SHALL provide parameters: ADDR_W, default 32, address width; DATA_W, default 128, data width; ID_W, default 4, ID width; WDEPTH, default 256, W-FIFO entries (power of 2, >=16); ADEPTH, default 4, AW-FIFO entries (power of 2).
REQ-002 SHALL provide ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  reset, asynchronous, active-low
- s_awid/s_awaddr/s_awlen  in  ID_W/ADDR_W/8  upstream AW payload
- s_awvalid in 1, s_awready out 1  upstream AW handshake
- s_wdata/s_wstrb/s_wlast  in  DATA_W/DATA_W/8/1  upstream W payload
- s_wvalid in 1, s_wready out 1  upstream W handshake
- m_awid/m_awaddr/m_awlen  out  ID_W/ADDR_W/8  downstream AW payload, feeds axi4 write pipe
- m_awvalid out 1, m_awready in 1  downstream AW handshake
- m_wdata/m_wstrb/m_wlast  out  DATA_W/DATA_W/8/1  downstream W payload
- m_wvalid out 1, m_wready in 1  downstream W handshake
- err_len_ovf  out  1  sticky burst-too-long flag
REQ-003 SHALL pass B channel outside this block (not handled here).

Function
REQ-004 SHALL buffer AW beats in an ADEPTH FIFO; s_awready = AW-FIFO not full.
REQ-005 SHALL buffer W beats {data,strb,last} in a WDEPTH FIFO; s_wready = W-FIFO not full.
REQ-006 SHALL keep counter bursts_rdy (width clog2(WDEPTH)+1): +1 on s_wvalid&s_wready&s_wlast, -1 on m_awvalid&m_awready; simultaneous +1/-1 leaves value unchanged.
REQ-007 SHALL assert m_awvalid only when AW-FIFO non-empty and bursts_rdy>0; AW is never issued before its whole burst is stored.
REQ-008 SHALL keep counter bursts_rel: +1 on AW handshake, -1 on m_wvalid&m_wready&m_wlast; simultaneous events leave it unchanged.
REQ-009 SHALL assert m_wvalid only when W-FIFO non-empty and bursts_rel>0; once a burst is released its beats stream back-to-back while m_wready=1 (no bubbles).
REQ-010 SHALL keep m_aw*/m_w* payload stable while valid is high and ready low.
REQ-011 Latency: s_wlast accepted in cycle N with AW already queued -> m_awvalid high in N+1; AW handshake in cycle M -> m_wvalid high in M+1.
REQ-012 W data arriving before its AW SHALL be accepted and counted; AW/W pairing strictly in order.
REQ-013 FIFO pointers SHALL wrap modulo depth; full/empty distinguished by extra pointer bit.

Reset
REQ-014 On axi_aresetn=0 (any time, incl. mid-burst) SHALL asynchronously clear FIFOs, both counters and err_len_ovf; outputs reset: s_awready=0, s_wready=0, m_awvalid=0, m_wvalid=0, m_wlast=0, payloads 0.
REQ-015 s_awready/s_wready SHALL rise in the first clock after reset deassertion.

Configuration
REQ-016 Macro AXI4_WR_STORE_FWD_LENCHK_EN defined: accepted AW with s_awlen+1 > WDEPTH SHALL set err_len_ovf in the next cycle, held until reset; AW still queued.
REQ-017 Macro undefined: err_len_ovf SHALL be constant 0, no checking logic.

Verification
REQ-018 Single burst awlen=3, W beats D0..D3 contiguous, m_ready=1 -> m_awvalid one cycle after D3 accepted; D0..D3 out on 4 consecutive cycles after AW handshake, m_wlast with D3.
REQ-019 W burst (len 2) sent 5 cycles before its AW -> W accepted immediately; m_awvalid cycle after AW accepted; output order intact.
REQ-020 Fill: WDEPTH=16, m_awready=0, send 16 single-beat bursts -> s_wready=0 after 16th beat; s_awready=0 after 4th AW; release m_awready -> all 16 emitted in order.
REQ-021 m_wready toggled 1/0 per cycle during burst len 7 -> m_wdata held stable on stall cycles, 8 beats, no loss/duplication.
REQ-022 axi_aresetn pulsed low mid-burst (beat 2 of 4) -> all valids 0 immediately, FIFOs empty, next burst after reset passes correctly.
REQ-023 LENCHK_EN defined, WDEPTH=16, s_awlen=16 -> err_len_ovf=1 next cycle, stays 1; undefined -> stays 0.
